mem_access_unit: RTL

Memory-stage access controller for the 5-stage MIPS pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Takes the load/store request presented by EX/MEM and drives it onto a variable-latency valid/ready data bus.
- Aligns and extends load data before it enters MEM/WB.
- Produces the pipeline-wide enable that stalls the EX/MEM and MEM/WB registers until the access completes.

---
 rtl/mips_mem_pkg.sv | 49 ++++
 rtl/mem_access_unit_load_align.sv | 16 +
 rtl/mem_access_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MEM-stage access path: size codes, FSM states,
// byte-enable / store-lane / load-extract functions. No logic of its own.
// Pure combinational helpers; no flow control.
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} memState_t;

    // Size code 2'b11 falls into the default (word) arm everywhere below.
    function automatic logic isAligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~off[0];
            default: return off == 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wdata_replicate(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: return {4{wdata[7:0]}};
            SZ_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] off,
                                                 input logic [1:0] size, input logic isUnsigned);
        logic [31:0] shifted;
        shifted = rdata >> {off, 3'b000};
        case (size)
            SZ_BYTE: return isUnsigned ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: return isUnsigned ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            // Words are always aligned here, so the shift is zero and rdata passes unchanged.
            default: return shifted;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load data aligner: selects the addressed byte/half of the read word and extends it.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module mem_load_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addrOff,
    input  logic [1:0]  size,
    input  logic        isUnsigned,
    output logic [31:0] data
);

    assign data = load_extract(rdata, addrOff, size, isUnsigned);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller between EX/MEM and MEM/WB, driving a valid/ready data bus.
// Latency: store >= 3 cycles, load >= 4 cycles (IDLE, REQ, WAIT, DONE); timeout bounds WAIT.
// Backpressure: holds the request while bus_req_ready is low; pipe_enable stalls the pipe until DONE.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [1:0]  ex_size,
    input  logic        ex_unsigned,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_req_we,
    output logic [31:0] bus_req_addr,
    output logic [3:0]  bus_req_be,
    output logic [31:0] bus_req_wdata,
    input  logic        bus_resp_valid,
    input  logic [31:0] bus_resp_rdata,
    output logic [31:0] load_data,
    output logic        pipe_enable,
    output logic        mem_exc,
    output logic        bus_error
);

    memState_t        state;
    logic [CNT_W-1:0] counter;
    logic [1:0]       latchedOff;
    logic [1:0]       latchedSize;
    logic             latchedUnsigned;
    logic             aligned;
    logic             isMemOp;
    logic             access;
    logic [31:0]      alignedData;

    assign isMemOp = ex_valid & (ex_mem_read | ex_mem_write);
    assign aligned = isAligned(ex_size, ex_addr[1:0]);
    assign access  = isMemOp & aligned;
    assign mem_exc = isMemOp & ~aligned;

    always_comb begin
        pipe_enable = 1'b0;
        case (state)
            IDLE:    pipe_enable = ~access;
            DONE:    pipe_enable = 1'b1;
            default: pipe_enable = 1'b0;
        endcase
    end

    mem_load_align u_loadAlign (
        .rdata      (bus_resp_rdata),
        .addrOff    (latchedOff),
        .size       (latchedSize),
        .isUnsigned (latchedUnsigned),
        .data       (alignedData)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            counter         <= '0;
            load_data       <= '0;
            bus_req_valid   <= 1'b0;
            bus_req_we      <= 1'b0;
            bus_req_addr    <= '0;
            bus_req_be      <= '0;
            bus_req_wdata   <= '0;
            bus_error       <= 1'b0;
            latchedOff      <= '0;
            latchedSize     <= '0;
            latchedUnsigned <= 1'b0;
        end else begin
            bus_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (access) begin
                        bus_req_valid   <= 1'b1;
                        // A read+write instruction is treated as a load.
                        bus_req_we      <= ~ex_mem_read;
                        bus_req_addr    <= {ex_addr[31:2], 2'b00};
                        bus_req_be      <= be_gen(ex_size, ex_addr[1:0]);
                        bus_req_wdata   <= wdata_replicate(ex_size, ex_wdata);
                        latchedOff      <= ex_addr[1:0];
                        latchedSize     <= ex_size;
                        latchedUnsigned <= ex_unsigned;
                        state           <= REQ;
                    end
                end
                REQ: begin
                    if (bus_req_ready) begin
                        bus_req_valid <= 1'b0;
                        counter       <= '0;
                        state         <= bus_req_we ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (bus_resp_valid) begin
                        load_data <= alignedData;
                        state     <= DONE;
                    end else if (counter == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        load_data <= '0;
                        bus_error <= 1'b1;
                        state     <= DONE;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
